// File: rtl/fp_divsqrt_share_ctrl.sv
// ---------------------------------------------------------------------------
// fp_divsqrt_share_ctrl
//
// Purpose: shares one iterative FP divide/sqrt unit between NUM_LANES FP
// issue lanes. It arbitrates reservations from the issue queue round-robin,
// then tracks the single owner through start, completion, release and
// selective-flush abort.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   reserve_req     [NUM_LANES] issue queue wants the unit for lane i
//   reserve_grant   [NUM_LANES] one-hot grant, combinational, only in FREE
//   reserved        [NUM_LANES] one-hot, lane i owns the unit
//   exec_req        [NUM_LANES] lane i has the op in EX with operands valid
//   flush           [NUM_LANES] selective flush hits lane i's op
//   release_lane    [NUM_LANES] lane i consumed the result (the name
//                   "release" is a reserved word)
//   unit_start      one-cycle start pulse to the unit
//   unit_lane       current owner index (0 when FREE)
//   unit_abort      one-cycle kill to the unit
//   unit_done       unit result valid (pulse or level)
//   finished        [NUM_LANES] result ready for owner
//   busy            unit is not FREE
//
// state     | meaning
// ----------+------------------------------------------------------------
// FREE      | no owner, grant offered to the next requester (round robin)
// RESERVED  | owner holds the unit, waiting for exec_req (may time out)
// BUSY      | unit computing for the owner
// DONE      | result ready, waiting for owner release
// ---------------------------------------------------------------------------
module fp_divsqrt_share_ctrl #(
  parameter int NUM_LANES       = 2,
  parameter int RESERVE_TIMEOUT = 64,
  parameter int LANE_W          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] reserve_req,
  output logic [NUM_LANES-1:0] reserve_grant,
  output logic [NUM_LANES-1:0] reserved,
  input  logic [NUM_LANES-1:0] exec_req,
  input  logic [NUM_LANES-1:0] flush,
  input  logic [NUM_LANES-1:0] release_lane,
  output logic                 unit_start,
  output logic [LANE_W-1:0]    unit_lane,
  output logic                 unit_abort,
  input  logic                 unit_done,
  output logic [NUM_LANES-1:0] finished,
  output logic                 busy
);

  localparam int TMO_W = (RESERVE_TIMEOUT > 0) ? $clog2(RESERVE_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((RESERVE_TIMEOUT > 0) ? RESERVE_TIMEOUT - 1 : 0);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    S_FREE     = 2'd0,
    S_RESERVED = 2'd1,
    S_BUSY     = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t             state;
  logic [LANE_W-1:0]  owner;
  logic [LANE_W-1:0]  rr_ptr;
  logic [TMO_W-1:0]   tmo_cnt;

  logic               grant_any;
  logic [LANE_W-1:0]  grant_idx;

  logic               own_flush;
  logic               own_exec;
  logic               own_release;

  // Round-robin scan starting at rr_ptr, wrapping at NUM_LANES.
  always_comb begin
    int idx;
    logic [LANE_W-1:0] sel;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    sel       = '0;
    for (int off = 0; off < NUM_LANES; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      sel = LANE_W'(idx);
      if (!grant_any && reserve_req[sel]) begin
        grant_any = 1'b1;
        grant_idx = sel;
      end
    end
  end

  // Only the owner's lane signals matter; everything else is ignored.
  assign own_flush   = flush[owner];
  assign own_exec    = exec_req[owner];
  assign own_release = release_lane[owner];

  // Mealy outputs are masked during reset so a reset taken mid-operation
  // never produces a grant, start or abort pulse.
  assign reserve_grant = (!rst && state == S_FREE && grant_any)
                         ? (NUM_LANES'(1) << grant_idx) : '0;
  assign unit_start    = !rst && state == S_RESERVED && !own_flush && own_exec;
  assign unit_abort    = !rst && state == S_BUSY && own_flush;

  // Moore outputs decode state/owner only.
  assign busy      = (state != S_FREE);
  assign reserved  = busy ? (NUM_LANES'(1) << owner) : '0;
  assign finished  = (state == S_DONE) ? (NUM_LANES'(1) << owner) : '0;
  assign unit_lane = busy ? owner : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FREE;
      owner   <= '0;
      rr_ptr  <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        S_FREE: begin
          if (grant_any) begin
            state   <= S_RESERVED;
            owner   <= grant_idx;
            rr_ptr  <= (grant_idx == LAST_LANE) ? '0 : grant_idx + 1'b1;
            tmo_cnt <= '0;
          end
        end
        S_RESERVED: begin
          if (own_flush) begin
            state <= S_FREE;
          end else if (own_exec) begin
            state <= S_BUSY;
          end else if (RESERVE_TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
            state <= S_FREE;
          end else if (RESERVE_TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_BUSY: begin
          // Flush wins over a same-cycle unit_done; the result is dropped.
          if (own_flush) begin
            state <= S_FREE;
          end else if (unit_done) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (own_flush || own_release) begin
            state <= S_FREE;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divsqrt_share_ctrl.sv
module tb_fp_divsqrt_share_ctrl;

  localparam int N  = 2;
  localparam int NI = 3;

  // Instance 0: timeout 64, instance 1: timeout 4, instance 2: timeout disabled
  int tmo_of [NI] = '{64, 4, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0, exe = '0, fl = '0, rl = '0;
  logic dn = 1'b0;

  logic [N-1:0] g_o [NI];
  logic [N-1:0] r_o [NI];
  logic [N-1:0] f_o [NI];
  logic         s_o [NI];
  logic         a_o [NI];
  logic         b_o [NI];
  logic [0:0]   l_o [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    fp_divsqrt_share_ctrl #(
      .NUM_LANES(N),
      .RESERVE_TIMEOUT(k == 0 ? 64 : (k == 1 ? 4 : 0))
    ) dut (
      .clk(clk),
      .rst(rst),
      .reserve_req(req),
      .reserve_grant(g_o[k]),
      .reserved(r_o[k]),
      .exec_req(exe),
      .flush(fl),
      .release_lane(rl),
      .unit_start(s_o[k]),
      .unit_lane(l_o[k]),
      .unit_abort(a_o[k]),
      .unit_done(dn),
      .finished(f_o[k]),
      .busy(b_o[k])
    );
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: per instance, owner lane (-1 = nobody), phase of
  // the owner's operation, cycles spent waiting in reservation, next lane
  // to be preferred by the round robin.
  localparam int PH_WAIT = 1, PH_RUN = 2, PH_RES = 3;
  int m_own  [NI] = '{-1, -1, -1};
  int m_ph   [NI] = '{0, 0, 0};
  int m_wait [NI] = '{0, 0, 0};
  int m_next [NI] = '{0, 0, 0};
  bit seen_rst = 1'b0;
  int gl, eg, er, ef, es, ea, eb, el;

  always @(posedge clk) if (rst) seen_rst <= 1'b1;

  always @(negedge clk) begin
    if (seen_rst) begin
      for (int k = 0; k < NI; k++) begin
        gl = -1;
        for (int off = 0; off < N; off++)
          if (gl < 0 && req[(m_next[k] + off) % N]) gl = (m_next[k] + off) % N;
        eg = 0; es = 0; ea = 0;
        if (!rst) begin
          if (m_own[k] < 0 && gl >= 0) eg = 1 << gl;
          if (m_own[k] >= 0 && m_ph[k] == PH_WAIT && !fl[m_own[k]] && exe[m_own[k]]) es = 1;
          if (m_own[k] >= 0 && m_ph[k] == PH_RUN && fl[m_own[k]]) ea = 1;
        end
        eb = (m_own[k] >= 0) ? 1 : 0;
        er = (m_own[k] >= 0) ? (1 << m_own[k]) : 0;
        ef = (m_own[k] >= 0 && m_ph[k] == PH_RES) ? (1 << m_own[k]) : 0;
        el = (m_own[k] >= 0) ? m_own[k] : 0;
        chk($sformatf("m%0d_grant", k), int'(g_o[k]), eg);
        chk($sformatf("m%0d_reserved", k), int'(r_o[k]), er);
        chk($sformatf("m%0d_finished", k), int'(f_o[k]), ef);
        chk($sformatf("m%0d_start", k), int'(s_o[k]), es);
        chk($sformatf("m%0d_abort", k), int'(a_o[k]), ea);
        chk($sformatf("m%0d_busy", k), int'(b_o[k]), eb);
        chk($sformatf("m%0d_lane", k), int'(l_o[k]), el);
        // advance model to the state after the coming edge
        if (rst) begin
          m_own[k] = -1; m_ph[k] = 0; m_wait[k] = 0; m_next[k] = 0;
        end else if (m_own[k] < 0) begin
          if (gl >= 0) begin
            m_own[k] = gl; m_ph[k] = PH_WAIT; m_wait[k] = 0; m_next[k] = (gl + 1) % N;
          end
        end else if (fl[m_own[k]]) begin
          m_own[k] = -1;
        end else if (m_ph[k] == PH_WAIT) begin
          if (exe[m_own[k]]) m_ph[k] = PH_RUN;
          else begin
            m_wait[k]++;
            if (tmo_of[k] != 0 && m_wait[k] == tmo_of[k]) m_own[k] = -1;
          end
        end else if (m_ph[k] == PH_RUN) begin
          if (dn) m_ph[k] = PH_RES;
        end else if (rl[m_own[k]]) begin
          m_own[k] = -1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_busy", int'(b_o[0]), 0);
    chk("rst_reserved", int'(r_o[0]), 0);
    rst = 1'b0;

    // first grant from rr_ptr=0
    req = 2'b11; #1;
    chk("rr_first_grant", int'(g_o[0]), 1);
    cyc(); req = 2'b00;
    chk("own0_reserved", int'(r_o[0]), 1);

    // non-owner exec_req ignored for two cycles
    exe = 2'b10; #1;
    chk("nonowner_no_start", int'(s_o[0]), 0);
    cyc();
    chk("nonowner_still_res", int'(r_o[0]), 1);
    cyc();

    // owner start at cycle t
    exe = 2'b01; #1;
    chk("start_at_t", int'(s_o[0]), 1);
    chk("start_lane", int'(l_o[0]), 0);
    cyc(); exe = 2'b00;                       // t+1
    chk("busy_t1", int'(b_o[0]), 1);
    repeat (9) cyc();                         // t+10
    chk("not_finished_t10", int'(f_o[0]), 0);
    dn = 1'b1;
    cyc(); dn = 1'b0;                         // t+11
    chk("finished_t11", int'(f_o[0]), 1);
    cyc(); dn = 1'b1;                         // t+12, done outside BUSY
    cyc(); dn = 1'b0;                         // t+13
    rl = 2'b01; req = 2'b11; #1;
    chk("no_grant_on_release", int'(g_o[0]), 0);
    chk("finished_t13", int'(f_o[0]), 1);
    cyc(); rl = 2'b00;                        // t+14
    chk("busy_t14", int'(b_o[0]), 0);
    chk("finished_drop", int'(f_o[0]), 0);
    #1;
    chk("rr_second_grant", int'(g_o[0]), 2);
    cyc(); req = 2'b00;
    chk("own1_reserved", int'(r_o[0]), 2);

    // lane1 full op, non-owner release ignored
    exe = 2'b10; #1;
    chk("start_lane1", int'(l_o[0]), 1);
    cyc(); exe = 2'b00; dn = 1'b1;
    cyc(); dn = 1'b0;
    chk("finished_lane1", int'(f_o[0]), 2);
    rl = 2'b01;
    cyc();
    chk("nonowner_release_ign", int'(f_o[0]), 2);
    rl = 2'b10;
    cyc(); rl = 2'b00;
    chk("lane1_released", int'(b_o[0]), 0);

    // flush in BUSY with same-cycle unit_done
    req = 2'b11; #1;
    chk("rr_wrap_grant", int'(g_o[0]), 1);
    cyc(); req = 2'b00; exe = 2'b01;
    cyc(); exe = 2'b00; dn = 1'b1; fl = 2'b01; #1;
    chk("abort_over_done", int'(a_o[0]), 1);
    chk("no_start_on_abort", int'(s_o[0]), 0);
    cyc(); dn = 1'b0; fl = 2'b00;
    chk("free_after_abort", int'(b_o[0]), 0);
    chk("no_finish_abort", int'(f_o[0]), 0);
    cyc();

    // flush in RESERVED
    req = 2'b11;
    cyc(); req = 2'b00; fl = 2'b10;
    cyc(); fl = 2'b00;
    chk("flush_res_free", int'(b_o[0]), 0);

    // flush in DONE: no abort
    req = 2'b01;
    cyc(); req = 2'b00; exe = 2'b01;
    cyc(); exe = 2'b00; dn = 1'b1;
    cyc(); dn = 1'b0; fl = 2'b01; #1;
    chk("flush_done_no_abort", int'(a_o[0]), 0);
    cyc(); fl = 2'b00;
    chk("flush_done_free", int'(b_o[0]), 0);

    // reservation timeout: 4 / 64 / disabled
    req = 2'b10; #1;
    chk("tmo_grant", int'(g_o[1]), 2);
    cyc(); req = 2'b00;                       // reserved cycle 1
    chk("t4_res_c1", int'(r_o[1]), 2);
    repeat (3) cyc();                         // cycle 4
    chk("t4_res_c4", int'(r_o[1]), 2);
    cyc();
    chk("t4_free", int'(b_o[1]), 0);
    repeat (59) cyc();                        // cycle 64
    chk("t64_res_c64", int'(r_o[0]), 2);
    cyc();
    chk("t64_free", int'(b_o[0]), 0);
    repeat (35) cyc();                        // cycle 100
    chk("t0_res_100", int'(r_o[2]), 2);

    // reset while BUSY
    req = 2'b01;
    cyc(); req = 2'b00; exe = 2'b01;
    cyc(); exe = 2'b00;
    chk("busy_before_rst", int'(b_o[0]), 1);
    rst = 1'b1; fl = 2'b01; #1;
    chk("no_abort_in_rst", int'(a_o[0]), 0);
    cyc(); rst = 1'b0; fl = 2'b00;
    chk("rst_busy_clear", int'(b_o[0]), 0);
    chk("rst_res_clear", int'(r_o[0]), 0);
    chk("rst_lane_clear", int'(l_o[0]), 0);
    chk("rst_t0_clear", int'(b_o[2]), 0);
    req = 2'b10; #1;
    chk("post_rst_grant", int'(g_o[0]), 2);
    cyc(); req = 2'b00;
    chk("post_rst_res", int'(r_o[0]), 2);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_divsqrt_share_ctrl.md
Name: fp_divsqrt_share_ctrl

Overview:
- Controller that shares one iterative FP divide/sqrt unit between NUM_LANES FP issue lanes.
- Handles reservation arbitration from the FP issue queue, the start pulse to the unit, result-ready indication to the owning lane's execution pipeline, release, and selective-flush abort.
- Sits between the FP scheduler/issue queue, the FP execution stage lanes and the div/sqrt datapath. It replaces the per-lane Reserved/Req/Finished/Release bookkeeping with a single arbitrated owner.

Parameters:
- NUM_LANES, 2, number of FP issue lanes sharing the unit (≥1).
- RESERVE_TIMEOUT, 64, cycles a reservation may sit without exec_req before it is forcibly dropped; 0 disables the timeout.
- LANE_W, $clog2(NUM_LANES) (min 1), width of lane index.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reserve_req  in  NUM_LANES  issue queue wants to issue a div/sqrt op on lane i
- reserve_grant  out  NUM_LANES  one-hot grant, combinational, valid only in FREE
- reserved  out  NUM_LANES  one-hot, lane i currently owns the unit (RESERVED/BUSY/DONE)
- exec_req  in  NUM_LANES  lane i has the op in EX with all operands valid
- flush  in  NUM_LANES  selective flush hits lane i's div/sqrt op
- release  in  NUM_LANES  lane i has consumed the result at last EX stage
- unit_start  out  1  one-cycle start pulse to the div/sqrt unit
- unit_lane  out  LANE_W  current owner index
- unit_abort  out  1  one-cycle kill to the unit
- unit_done  in  1  unit result valid (pulse or level)
- finished  out  NUM_LANES  result ready for owner (DONE state)
- busy  out  1  state != FREE

Behaviour:
- States: FREE, RESERVED, BUSY, DONE.
- Registers: state, owner (LANE_W), rr_ptr (LANE_W), tmo_cnt (≥ $clog2(RESERVE_TIMEOUT+1) bits).
- Reset: state=FREE, owner=0, rr_ptr=0, tmo_cnt=0. All outputs 0, i.e. reserve_grant=0, reserved=0, finished=0, unit_start=0, unit_abort=0, busy=0, unit_lane=0.
- Reset mid-operation: returns to FREE with no abort pulse. The unit is reset by the same rst.
- FREE:
  - Grant goes to the first lane with reserve_req set, scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1 … NUM_LANES-1, 0 …).
  - reserve_grant is asserted the same cycle.
  - Next cycle: state=RESERVED, owner=granted lane, rr_ptr=(granted+1) mod NUM_LANES, tmo_cnt=0.
  - No request means the state is held.
- RESERVED:
  - flush[owner] → FREE.
  - Otherwise exec_req[owner] → unit_start=1 this cycle (combinational), unit_lane=owner, next state BUSY.
  - Otherwise, if RESERVE_TIMEOUT≠0 and tmo_cnt==RESERVE_TIMEOUT-1 → FREE. Else tmo_cnt+1.
  - exec_req/flush/release from non-owners are ignored in all states.
- BUSY:
  - flush[owner] → unit_abort=1 this cycle, next FREE. This takes priority over a same-cycle unit_done.
  - Otherwise unit_done → DONE.
- DONE:
  - finished[owner]=1 (registered, from state).
  - flush[owner] → FREE, no abort.
  - Otherwise release[owner] → FREE.
  - finished drops the cycle after release.
  - A new grant is possible in the cycle after returning to FREE, never in the same cycle as release.
- unit_done outside BUSY is ignored.
- Outputs reserved/finished/busy/unit_lane decode state/owner only, with no combinational path from inputs.
- unit_start, unit_abort and reserve_grant are the only combinational (Mealy) outputs.
- Invariants: at most one bit set in reserve_grant, reserved and finished; unit_start and unit_abort are never asserted together.

Test Plan:
- rst=1 for 2 cycles, then reserve_req=2'b11 with rr_ptr=0 → grant=2'b01, next cycle reserved=2'b01, rr_ptr=1. After release, repeat reserve_req=2'b11 → grant=2'b10 (round robin).
- Owner lane0: exec_req[0] at cycle t → unit_start=1 at t, busy. unit_done at t+10 → finished=2'b01 at t+11. release[0] at t+13 → busy=0 at t+14.
- exec_req[1] while lane0 owns in RESERVED → no unit_start, state stays RESERVED.
- flush[0] in BUSY the same cycle as unit_done → unit_abort=1, finished never asserted, FREE next cycle.
- RESERVE_TIMEOUT=4, lane1 reserved with no exec_req → FREE after exactly 4 RESERVED cycles. With RESERVE_TIMEOUT=0 it stays reserved for 100 cycles.
- rst asserted in BUSY → all outputs 0 next cycle, no unit_abort pulse. The following reserve_req=2'b10 is granted to lane1.
